// File: rtl/ats21_pkg.sv
// Shared widths, status codes and FSM state type for the ATS21 scheduler.
package ats21_pkg;
    localparam int CTRL_W = 16;
    localparam int DATA_W = 24;
    localparam int STAT_W = 2;
    localparam logic [STAT_W-1:0] STAT_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } ats_sched_state_t;
endpackage

// File: rtl/ats21_if.sv
// Scheduler-to-ATS21 request/completion bundle.
interface ats21_if;
    import ats21_pkg::*;

    logic              ats_req;
    logic [CTRL_W-1:0] ats_ctrlA;
    logic [CTRL_W-1:0] ats_ctrlB;
    logic              ats_ready;
    logic [STAT_W-1:0] ats_stat;
    logic [DATA_W-1:0] ats_data;

    modport master (
        output ats_req, ats_ctrlA, ats_ctrlB,
        input  ats_ready, ats_stat, ats_data
    );

    modport slave (
        input  ats_req, ats_ctrlA, ats_ctrlB,
        output ats_ready, ats_stat, ats_data
    );
endinterface

// File: rtl/ats21_rr_pick.sv
// Combinational round-robin pick starting one past the last grant.
module ats21_rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic          valid,
    output logic [IW-1:0] win
);
    logic [IW-1:0] idx;

    // Scan farthest-first so the nearest requester after last overrides.
    always_comb begin
        valid = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = N; k >= 1; k--) begin
            idx = IW'((int'(last) + k) % N);
            if (req[idx]) begin
                valid = 1'b1;
                win   = idx;
            end
        end
    end
endmodule

// File: rtl/ats21_sched.sv
// Round-robin scheduler sharing one ATS21 unit among N_CLI clients.
module ats21_sched
    import ats21_pkg::*;
#(
    parameter int N_CLI   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_CLI-1:0]              cli_req,
    input  logic [N_CLI-1:0][CTRL_W-1:0]  cli_ctrlA,
    input  logic [N_CLI-1:0][CTRL_W-1:0]  cli_ctrlB,
    output logic [N_CLI-1:0]              cli_gnt,
    output logic [N_CLI-1:0]              cli_done,
    output logic [DATA_W-1:0]             rsp_data,
    output logic [STAT_W-1:0]             rsp_stat,
    output logic                          rsp_timeout,
    output logic                          busy,
    ats21_if.master                       ats
);
    localparam int IW = $clog2(N_CLI);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [N_CLI-1:0] ONE    = N_CLI'(1);
    localparam logic [TW-1:0]    T_LOAD = TW'(TIMEOUT - 1);

    ats_sched_state_t state;
    logic [IW-1:0]    win_q;
    logic [IW-1:0]    last_q;
    logic [IW-1:0]    pick_w;
    logic             pick_v;
    logic [TW-1:0]    timer;

    ats21_rr_pick #(.N(N_CLI)) u_pick (
        .req   (cli_req),
        .last  (last_q),
        .valid (pick_v),
        .win   (pick_w)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            win_q         <= '0;
            last_q        <= IW'(N_CLI - 1);
            timer         <= '0;
            cli_gnt       <= '0;
            cli_done      <= '0;
            rsp_data      <= '0;
            rsp_stat      <= '0;
            rsp_timeout   <= 1'b0;
            ats.ats_req   <= 1'b0;
            ats.ats_ctrlA <= '0;
            ats.ats_ctrlB <= '0;
        end else begin
            cli_gnt     <= '0;
            cli_done    <= '0;
            ats.ats_req <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pick_v) begin
                        win_q         <= pick_w;
                        ats.ats_ctrlA <= cli_ctrlA[pick_w];
                        ats.ats_ctrlB <= cli_ctrlB[pick_w];
                        cli_gnt       <= ONE << pick_w;
                        ats.ats_req   <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    timer <= T_LOAD;
                    state <= WAIT;
                end
                WAIT: begin
                    // A completion on the final timer cycle still counts.
                    if (ats.ats_ready) begin
                        rsp_data    <= ats.ats_data;
                        rsp_stat    <= ats.ats_stat;
                        rsp_timeout <= 1'b0;
                        cli_done    <= ONE << win_q;
                        state       <= RESP;
                    end else if (timer == '0) begin
                        rsp_data    <= '0;
                        rsp_stat    <= STAT_TIMEOUT;
                        rsp_timeout <= 1'b1;
                        cli_done    <= ONE << win_q;
                        state       <= RESP;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                RESP: begin
                    last_q <= win_q;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ats21_sched.sv
// Directed table-driven bench for ats21_sched (N_CLI=4, TIMEOUT=8).
module tb_ats21_sched;
    import ats21_pkg::*;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [3:0]       cli_req = '0;
    logic [3:0][15:0] cli_ctrlA;
    logic [3:0][15:0] cli_ctrlB;
    logic [3:0]       cli_gnt;
    logic [3:0]       cli_done;
    logic [23:0]      rsp_data;
    logic [1:0]       rsp_stat;
    logic             rsp_timeout;
    logic             busy;

    ats21_if ats();

    ats21_sched #(.N_CLI(4), .TIMEOUT(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .cli_req     (cli_req),
        .cli_ctrlA   (cli_ctrlA),
        .cli_ctrlB   (cli_ctrlB),
        .cli_gnt     (cli_gnt),
        .cli_done    (cli_done),
        .rsp_data    (rsp_data),
        .rsp_stat    (rsp_stat),
        .rsp_timeout (rsp_timeout),
        .busy        (busy),
        .ats         (ats)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        int          dly;
        logic [23:0] data;
        logic [1:0]  stat;
        logic [3:0]  gnt;
        logic [23:0] e_data;
        logic [1:0]  e_stat;
        logic        e_to;
        int          e_lat;
    } vec_t;

    vec_t        vt[11];
    logic [15:0] ca[4];
    logic [15:0] cb[4];
    int          n_err = 0;
    int          n_chk = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int          w = 0;
        int          lat = 0;
        logic [15:0] ea;
        logic [15:0] eb;
        for (int i = 0; i < 4; i++) if (v.gnt[i]) w = i;
        ea = ca[w];
        eb = cb[w];
        cli_req = v.req;
        @(negedge clk);
        chk({tag, ".gnt"}, 64'(cli_gnt), 64'(v.gnt));
        chk({tag, ".ats_req"}, 64'(ats.ats_req), 64'd1);
        chk({tag, ".ctrlA"}, 64'(ats.ats_ctrlA), 64'(ea));
        chk({tag, ".ctrlB"}, 64'(ats.ats_ctrlB), 64'(eb));
        chk({tag, ".busy"}, 64'(busy), 64'd1);
        cli_req = '0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            ats.ats_ready = (c == v.dly);
            ats.ats_data  = v.data;
            ats.ats_stat  = v.stat;
            if (cli_done != '0) begin
                lat = c;
                break;
            end
            chk({tag, ".hold"},
                {31'd0, ats.ats_req, ats.ats_ctrlA, ats.ats_ctrlB},
                {31'd0, 1'b0, ea, eb});
        end
        ats.ats_ready = 1'b0;
        chk({tag, ".lat"}, 64'(lat), 64'(v.e_lat));
        chk({tag, ".done"}, 64'(cli_done), 64'(v.gnt));
        chk({tag, ".data"}, 64'(rsp_data), 64'(v.e_data));
        chk({tag, ".stat"}, 64'(rsp_stat), 64'(v.e_stat));
        chk({tag, ".to"}, 64'(rsp_timeout), 64'(v.e_to));
        @(negedge clk);
        chk({tag, ".idle"}, {62'd0, busy, |cli_done}, 64'd0);
        chk({tag, ".hold_data"}, 64'(rsp_data), 64'(v.e_data));
    endtask

    initial begin
        vec_t fin;
        ca = '{16'h0A00, 16'h0A11, 16'h1234, 16'h0A33};
        cb = '{16'h0B00, 16'h0B11, 16'hABCD, 16'h0B33};
        for (int i = 0; i < 4; i++) begin
            cli_ctrlA[i] = ca[i];
            cli_ctrlB[i] = cb[i];
        end
        ats.ats_ready = 1'b0;
        ats.ats_data  = '0;
        ats.ats_stat  = '0;

        // req, dly, data, stat, gnt, e_data, e_stat, e_to, e_lat
        vt[0]  = '{4'b1111, 1,  24'h000001, 2'b00, 4'b0001,
                   24'h000001, 2'b00, 1'b0, 2};
        vt[1]  = '{4'b1111, 2,  24'h000002, 2'b01, 4'b0010,
                   24'h000002, 2'b01, 1'b0, 3};
        vt[2]  = '{4'b1111, 1,  24'h000003, 2'b10, 4'b0100,
                   24'h000003, 2'b10, 1'b0, 2};
        vt[3]  = '{4'b1111, 1,  24'h000004, 2'b00, 4'b1000,
                   24'h000004, 2'b00, 1'b0, 2};
        vt[4]  = '{4'b1111, 1,  24'h000005, 2'b01, 4'b0001,
                   24'h000005, 2'b01, 1'b0, 2};
        vt[5]  = '{4'b0100, 3,  24'hC0FFEE, 2'b01, 4'b0100,
                   24'hC0FFEE, 2'b01, 1'b0, 4};
        vt[6]  = '{4'b1000, -1, 24'h777777, 2'b01, 4'b1000,
                   24'h000000, 2'b11, 1'b1, 9};
        vt[7]  = '{4'b0010, 2,  24'h123456, 2'b10, 4'b0010,
                   24'h123456, 2'b10, 1'b0, 3};
        vt[8]  = '{4'b0001, 8,  24'hABCDEF, 2'b01, 4'b0001,
                   24'hABCDEF, 2'b01, 1'b0, 9};
        vt[9]  = '{4'b0100, 9,  24'hFEDCBA, 2'b01, 4'b0100,
                   24'h000000, 2'b11, 1'b1, 9};
        vt[10] = '{4'b0011, 1,  24'h555555, 2'b00, 4'b0001,
                   24'h555555, 2'b00, 1'b0, 2};

        repeat (4) @(negedge clk);
        chk("rst.gnt", 64'(cli_gnt), 64'd0);
        chk("rst.done", 64'(cli_done), 64'd0);
        chk("rst.data", 64'(rsp_data), 64'd0);
        chk("rst.stat", 64'(rsp_stat), 64'd0);
        chk("rst.to", 64'(rsp_timeout), 64'd0);
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.ats_req", 64'(ats.ats_req), 64'd0);
        chk("rst.ctrl", {32'd0, ats.ats_ctrlA, ats.ats_ctrlB}, 64'd0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle.busy", 64'(busy), 64'd0);
        end

        for (int i = 0; i < 11; i++) run_vec(vt[i], $sformatf("v%0d", i));

        ats.ats_ready = 1'b1;
        ats.ats_data  = 24'h999999;
        ats.ats_stat  = 2'b10;
        repeat (2) @(negedge clk);
        ats.ats_ready = 1'b0;
        @(negedge clk);
        chk("stray.state", {62'd0, busy, |cli_done}, 64'd0);
        chk("stray.data", 64'(rsp_data), 64'h555555);
        chk("stray.stat", 64'(rsp_stat), 64'd0);

        cli_req = 4'b0010;
        @(negedge clk);
        chk("mid.gnt", 64'(cli_gnt), 64'b0010);
        cli_req = '0;
        repeat (2) @(negedge clk);
        chk("mid.busy_wait", 64'(busy), 64'd1);
        #2 reset = 1'b0;
        #1;
        chk("mid.async_busy", 64'(busy), 64'd0);
        chk("mid.async_out",
            {7'd0, ats.ats_req, cli_done, cli_gnt, ats.ats_ctrlA, rsp_data},
            64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        ats.ats_ready = 1'b1;
        ats.ats_data  = 24'h424242;
        @(negedge clk);
        ats.ats_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("late.ignored", {62'd0, busy, |cli_done}, 64'd0);
        end
        chk("late.data", 64'(rsp_data), 64'd0);

        fin = '{4'b1111, 1, 24'h0BEEF0, 2'b10, 4'b0001,
                24'h0BEEF0, 2'b10, 1'b0, 2};
        run_vec(fin, "post_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
